// File: rtl/profile_sampler_pkg.sv
// profile_sampler_pkg: op codes, state encodings and STATUS word layout
// shared by the profile_sampler_ci custom-instruction sampler.
package profile_sampler_pkg;

  localparam logic [2:0] OP_CONFIG = 3'd0;
  localparam logic [2:0] OP_START  = 3'd1;
  localparam logic [2:0] OP_STOP   = 3'd2;
  localparam logic [2:0] OP_POP    = 3'd3;
  localparam logic [2:0] OP_STATUS = 3'd4;
  localparam logic [2:0] OP_ARM    = 3'd5;

  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_RUN     = 2'b01;
  localparam logic [1:0] ST_STOPPED = 2'b10;
  localparam logic [1:0] ST_ARMED   = 2'b11;

  typedef struct packed {
    logic [1:0] state;
    logic       overflow;
    logic [4:0] rsvd;
    logic [7:0] lost;
    logic [7:0] fill;
    logic [7:0] depth;
  } status_t;

  function automatic logic [31:0] pack_status(
    input logic [1:0] st,
    input logic       ovf,
    input logic [7:0] lost,
    input logic [7:0] fill,
    input logic [7:0] depth
  );
    status_t s;
    s.state    = st;
    s.overflow = ovf;
    s.rsvd     = '0;
    s.lost     = lost;
    s.fill     = fill;
    s.depth    = depth;
    return s;
  endfunction

endpackage

// File: rtl/profile_sampler_ci_if.sv
// profile_sampler_ci_if: custom-instruction request/response bundle.
// master = CPU side, slave = the sampler.
interface profile_sampler_ci_if;
  logic        start;
  logic [7:0]  cIn;
  logic [31:0] valueA;
  logic [31:0] valueB;
  logic        done;
  logic [31:0] result;

  modport master (
    output start, cIn, valueA, valueB,
    input  done, result
  );

  modport slave (
    input  start, cIn, valueA, valueB,
    output done, result
  );
endinterface

// File: rtl/profile_sampler_ci_fifo.sv
// sampler_fifo: synchronous FIFO with flush, combinational head and
// push accepted on a full FIFO when a pop happens in the same cycle.
module sampler_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int WIDTH      = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      wdata,
  output logic [WIDTH-1:0]      head,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   fill
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int FW    = DEPTH_LOG2 + 1;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;
  localparam logic [FW-1:0] CNT_FULL = FW'(DEPTH);

  logic [DEPTH_LOG2-1:0] wr_q, wr_d;
  logic [DEPTH_LOG2-1:0] rd_q, rd_d;
  logic [FW-1:0]         cnt_q, cnt_d;
  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic                  pop_ok;
  logic                  push_ok;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CNT_FULL);
  assign fill    = cnt_q;
  assign head    = mem_q[rd_q];
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  // pointer and occupancy next-state; flush wins over push/pop
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_ok) wr_d = wr_q + PTR_ONE;
      if (pop_ok)  rd_d = rd_q + PTR_ONE;
      cnt_d = cnt_q + FW'(push_ok) - FW'(pop_ok);
    end
  end

  // pointer and occupancy registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // storage array, written only on an accepted push
  always_ff @(posedge clock) begin
    if (push_ok && !flush) mem_q[wr_q] <= wdata;
  end

endmodule

// File: rtl/profile_sampler_ci.sv
// profile_sampler_ci: periodic counter-delta sampler behind a CI port.
// Optional external arm trigger: PROFILE_SAMPLER_TRIGGER_EN.
module profile_sampler_ci
  import profile_sampler_pkg::*;
#(
  parameter logic [7:0] customId   = 8'h00,
  parameter int         DEPTH_LOG2 = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  profile_sampler_ci_if.slave  ci,
  input  logic [31:0]          cnt0,
  input  logic [31:0]          cnt1,
  input  logic [31:0]          cnt2,
  input  logic [31:0]          cnt3
`ifdef PROFILE_SAMPLER_TRIGGER_EN
  ,
  input  logic                 trigger
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

`ifdef PROFILE_SAMPLER_TRIGGER_EN
  localparam logic ARM_EN = 1'b1;
  logic trig;
  assign trig = trigger;
`else
  localparam logic ARM_EN = 1'b0;
  logic trig;
  assign trig = 1'b0;
`endif

  logic [1:0]  state_q, state_d;
  logic [1:0]  sel_q, sel_d;
  logic [23:0] interval_q, interval_d;
  logic [23:0] down_q, down_d;
  logic [31:0] prev_q, prev_d;
  logic        ovf_q, ovf_d;
  logic [7:0]  lost_q, lost_d;

  logic        sel_hit;
  logic        op_config, op_start, op_stop;
  logic        op_pop, op_status, op_arm;
  logic [31:0] cnt_cur;
  logic [31:0] status;
  logic [31:0] result_w;

  logic              fifo_flush;
  logic              fifo_push;
  logic [31:0]       fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DEPTH_LOG2:0] fifo_fill;
  logic              pop_ok;

  logic idle, running, stopped, armed;
  logic expire, go;

  logic unused_bits;
  assign unused_bits = ^{ci.valueA[31:3], ci.valueB[7:2]};

  assign sel_hit = ci.start & (ci.cIn == customId) & ~reset;
  assign pop_ok  = op_pop & ~fifo_empty;

  assign idle    = (state_q == ST_IDLE);
  assign running = (state_q == ST_RUN);
  assign stopped = (state_q == ST_STOPPED);
  assign armed   = (state_q == ST_ARMED);
  assign expire  = running & (down_q == 24'd1);
  assign go      = op_start | (armed & trig & ~op_stop);

  assign status = pack_status(
    state_q, ovf_q, lost_q, 8'(fifo_fill), 8'(DEPTH)
  );

  // one-hot op decode, only while this block is selected
  always_comb begin
    op_config = 1'b0;
    op_start  = 1'b0;
    op_stop   = 1'b0;
    op_pop    = 1'b0;
    op_status = 1'b0;
    op_arm    = 1'b0;
    if (sel_hit) begin
      unique case (ci.valueA[2:0])
        OP_CONFIG: op_config = 1'b1;
        OP_START:  op_start  = 1'b1;
        OP_STOP:   op_stop   = 1'b1;
        OP_POP:    op_pop    = 1'b1;
        OP_STATUS: op_status = 1'b1;
        OP_ARM:    op_arm    = ARM_EN;
        default:   ;
      endcase
    end
  end

  // live value of the selected event counter
  always_comb begin
    cnt_cur = cnt0;
    unique case (sel_q)
      2'd0: cnt_cur = cnt0;
      2'd1: cnt_cur = cnt1;
      2'd2: cnt_cur = cnt2;
      2'd3: cnt_cur = cnt3;
      default: cnt_cur = cnt0;
    endcase
  end

  // combinational CI response in the request cycle
  always_comb begin
    result_w = '0;
    unique case (1'b1)
      op_config, op_status: result_w = status;
      op_pop: result_w = fifo_empty ? 32'd0 : fifo_head;
      default: result_w = '0;
    endcase
  end

  assign ci.done   = sel_hit;
  assign ci.result = result_w;

  // sampler control: config, start/stop/arm and interval countdown
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    interval_d = interval_q;
    down_d     = down_q;
    prev_d     = prev_q;
    ovf_d      = ovf_q;
    lost_d     = lost_q;
    fifo_flush = 1'b0;
    fifo_push  = 1'b0;

    if (op_config && (idle || stopped)) begin
      sel_d      = ci.valueB[1:0];
      interval_d = (ci.valueB[31:8] == 24'd0) ?
                   24'd1 : ci.valueB[31:8];
    end

    if (go) begin
      fifo_flush = 1'b1;
      ovf_d      = 1'b0;
      lost_d     = 8'd0;
      prev_d     = cnt_cur;
      down_d     = interval_q;
      state_d    = ST_RUN;
    end else if (op_stop) begin
      if (running || armed) state_d = ST_STOPPED;
    end else if (op_arm && (idle || stopped)) begin
      fifo_flush = 1'b1;
      state_d    = ST_ARMED;
    end else if (expire) begin
      fifo_push = 1'b1;
      prev_d    = cnt_cur;
      down_d    = interval_q;
      if (fifo_full && !pop_ok) begin
        ovf_d = 1'b1;
        if (lost_q != 8'hFF) lost_d = lost_q + 8'd1;
      end
    end else if (running) begin
      down_d = down_q - 24'd1;
    end
  end

  // control registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      sel_q      <= 2'd0;
      interval_q <= 24'd1;
      down_q     <= 24'd1;
      prev_q     <= 32'd0;
      ovf_q      <= 1'b0;
      lost_q     <= 8'd0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      interval_q <= interval_d;
      down_q     <= down_d;
      prev_q     <= prev_d;
      ovf_q      <= ovf_d;
      lost_q     <= lost_d;
    end
  end

  sampler_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (32)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .flush (fifo_flush),
    .push  (fifo_push),
    .pop   (op_pop),
    .wdata (cnt_cur - prev_q),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .fill  (fifo_fill)
  );

endmodule

// File: tb/tb_profile_sampler_ci.sv
// tb_profile_sampler_ci: directed + random CI traffic, scoreboard checked
// against a queue-based reference model of the sampler.
module tb_profile_sampler_ci;

  localparam logic [7:0] ID = 8'h5A;
  localparam int DL    = 4;
  localparam int DEPTH = 1 << DL;

  localparam logic [2:0] C_CONFIG = 3'd0;
  localparam logic [2:0] C_START  = 3'd1;
  localparam logic [2:0] C_STOP   = 3'd2;
  localparam logic [2:0] C_POP    = 3'd3;
  localparam logic [2:0] C_STATUS = 3'd4;
  localparam logic [2:0] C_ARM    = 3'd5;

  logic clock = 1'b0;
  logic reset;
  logic [31:0] cnt0, cnt1, cnt2, cnt3;
  logic trigger;

  profile_sampler_ci_if ci();

  profile_sampler_ci #(
    .customId   (ID),
    .DEPTH_LOG2 (DL)
  ) dut (
    .clock (clock),
    .reset (reset),
    .ci    (ci),
    .cnt0  (cnt0),
    .cnt1  (cnt1),
    .cnt2  (cnt2),
    .cnt3  (cnt3)
`ifdef PROFILE_SAMPLER_TRIGGER_EN
    ,
    .trigger (trigger)
`endif
  );

  always #5 clock = ~clock;

  // reference model state
  logic [1:0]  mst;
  logic [1:0]  msel;
  int          mint;
  int          mdown;
  logic [31:0] mprev;
  logic        mo;
  int          mlost;
  logic [31:0] mq[$];

  // scoreboard
  logic [31:0] expq[$];
  string       nameq[$];
  int total = 0;
  int bad   = 0;
  logic [31:0] mon_e;
  string       mon_n;

  function automatic logic [31:0] mstatus();
    return {mst, mo, 5'd0, 8'(mlost), 8'(mq.size()), 8'(DEPTH)};
  endfunction

  task automatic model_reset();
    mst = 2'b00; msel = 2'd0; mint = 1; mdown = 1;
    mprev = 32'd0; mo = 1'b0; mlost = 0;
    mq.delete();
  endtask

  task automatic model_step(input bit s, input logic [2:0] op,
                            input logic [31:0] b, input bit trig,
                            output logic [31:0] res);
    logic [31:0] c [4];
    bit go, stp, expire, was_armed;
    c[0] = cnt0; c[1] = cnt1; c[2] = cnt2; c[3] = cnt3;
    res = 32'd0; go = 0; stp = 0;
    was_armed = (mst == 2'b11);
    expire = (mst == 2'b01) && (mdown == 1);
    if (s) begin
      case (op)
        C_CONFIG: begin
          res = mstatus();
          if (mst == 2'b00 || mst == 2'b10) begin
            msel = b[1:0];
            mint = (b[31:8] == 0) ? 1 : int'(b[31:8]);
          end
        end
        C_START:  go = 1;
        C_STOP:   stp = 1;
        C_POP:    if (mq.size() > 0) res = mq.pop_front();
        C_STATUS: res = mstatus();
`ifdef PROFILE_SAMPLER_TRIGGER_EN
        C_ARM: if (mst == 2'b00 || mst == 2'b10) begin
          mq.delete(); mst = 2'b11;
        end
`endif
        default: ;
      endcase
    end
`ifdef PROFILE_SAMPLER_TRIGGER_EN
    if (was_armed && trig && !stp) go = 1;
`endif
    if (go) begin
      mq.delete(); mo = 0; mlost = 0;
      mprev = c[msel]; mdown = mint; mst = 2'b01;
    end else if (stp) begin
      if (mst == 2'b01 || mst == 2'b11) mst = 2'b10;
    end else if (expire) begin
      if (mq.size() < DEPTH) mq.push_back(c[msel] - mprev);
      else begin
        mo = 1;
        if (mlost < 255) mlost++;
      end
      mprev = c[msel]; mdown = mint;
    end else if (mst == 2'b01) begin
      mdown--;
    end
  endtask

  task automatic tick(input bit en, input bit hit, input logic [2:0] op,
                      input logic [31:0] b, input bit trig, input bit chk,
                      input logic [31:0] want, input string nm);
    logic [31:0] r;
    cnt0 = cnt0 + 32'd1;
    cnt1 = cnt1 + $urandom_range(0, 3);
    cnt2 = cnt2 + $urandom_range(5, 9);
    cnt3 = cnt3 + $urandom;
    ci.start  = en;
    ci.cIn    = hit ? ID : (ID ^ 8'h01);
    ci.valueA = $urandom;
    ci.valueA[2:0] = op;
    ci.valueB = b;
    trigger   = trig;
    model_step(en && hit, op, b, trig, r);
    if (en && hit) begin
      expq.push_back(chk ? want : r);
      nameq.push_back(nm);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 1, 3'd0, 32'd0, 0, 0, 32'd0, "idle");
  endtask

  task automatic op_chk(input logic [2:0] op, input logic [31:0] b,
                        input logic [31:0] want, input string nm);
    tick(1, 1, op, b, 0, 1, want, nm);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ci.start = 1'b0;
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  // monitor: every CI response is matched against the next expectation
  always @(negedge clock) begin
    if (!reset && ci.done) begin
      total++;
      if (expq.size() == 0) begin
        bad++;
        $display("FAIL unexpected_done got=%h want=none", ci.result);
      end else begin
        mon_e = expq.pop_front();
        mon_n = nameq.pop_front();
        if (ci.result !== mon_e) begin
          bad++;
          $display("FAIL %s got=%h want=%h", mon_n, ci.result, mon_e);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    cnt0 = 0; cnt1 = 0; cnt2 = 0; cnt3 = 0;
    trigger = 0;
    ci.start = 0; ci.cIn = 0; ci.valueA = 0; ci.valueB = 0;
    model_reset();
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // 1: interval 4, 20 cycles -> 5 deltas of 4
    op_chk(C_STATUS, 0, 32'h0000_0010, "reset_status");
    op_chk(C_CONFIG, 32'h0000_0400, 32'h0000_0010, "t1_config");
    op_chk(C_START, 0, 0, "t1_start");
    idle(20);
    op_chk(C_STOP, 0, 0, "t1_stop");
    op_chk(C_STATUS, 0, 32'h8000_0510, "t1_status");
    repeat (5) op_chk(C_POP, 0, 32'd4, "t1_pop");
    op_chk(C_POP, 0, 0, "t1_pop_empty");

    // 2: interval 1 overflow, lost 3
    op_chk(C_CONFIG, 32'h0000_0100, 32'h8000_0010, "t2_config");
    op_chk(C_START, 0, 0, "t2_start");
    idle(DEPTH + 3);
    op_chk(C_STOP, 0, 0, "t2_stop");
    op_chk(C_STATUS, 0, 32'hA003_1010, "t2_status_full");
    repeat (DEPTH) op_chk(C_POP, 0, 32'd1, "t2_drain");
    op_chk(C_STATUS, 0, 32'hA003_0010, "t2_status_drained");

    // 3: wrap-around delta
    op_chk(C_CONFIG, 32'h0000_0400, 32'hA003_0010, "t3_config");
    cnt0 = 32'hFFFF_FFFD;
    op_chk(C_START, 0, 0, "t3_start");
    idle(4);
    op_chk(C_STOP, 0, 0, "t3_stop");
    op_chk(C_POP, 0, 32'd4, "t3_wrap_pop");
    op_chk(C_STATUS, 0, 32'h8000_0010, "t3_status");

    // 4: full FIFO with POP on a sample cycle
    op_chk(C_CONFIG, 32'h0000_0100, 32'h8000_0010, "t4_config");
    op_chk(C_START, 0, 0, "t4_start");
    idle(DEPTH);
    op_chk(C_POP, 0, 32'd1, "t4_pop_on_sample");
    op_chk(C_STOP, 0, 0, "t4_stop");
    op_chk(C_STATUS, 0, 32'h8000_1010, "t4_status");

    // 5: STOP on expiry, CONFIG in RUN ignored
    op_chk(C_CONFIG, 32'h0000_0400, 32'h8000_1010, "t5_config");
    op_chk(C_START, 0, 0, "t5_start");
    op_chk(C_CONFIG, 32'h0000_0802, 32'h4000_0010, "t5_config_run");
    idle(2);
    op_chk(C_STOP, 0, 0, "t5_stop_expire");
    op_chk(C_STATUS, 0, 32'h8000_0010, "t5_status");
    op_chk(C_START, 0, 0, "t5_restart");
    idle(4);
    op_chk(C_STOP, 0, 0, "t5_stop2");
    op_chk(C_POP, 0, 32'd4, "t5_sel_kept");
    op_chk(C_POP, 0, 32'd0, "t5_single_entry");

    // 6: reset mid-RUN with 3 entries
    op_chk(C_CONFIG, 32'h0000_0200, 32'h8000_0010, "t6_config");
    op_chk(C_START, 0, 0, "t6_start");
    idle(6);
    op_chk(C_STATUS, 0, 32'h4000_0310, "t6_status_run");
    do_reset();
    op_chk(C_STATUS, 0, 32'h0000_0010, "t6_status_reset");
    op_chk(C_POP, 0, 32'd0, "t6_pop_reset");
    op_chk(C_START, 0, 0, "t6_start_default");
    idle(1);
    op_chk(C_STOP, 0, 0, "t6_stop");
    op_chk(C_POP, 0, 32'd1, "t6_interval_one");
    op_chk(C_POP, 0, 32'd0, "t6_pop_empty");

`ifdef PROFILE_SAMPLER_TRIGGER_EN
    // 7: ARM waits for trigger
    op_chk(C_ARM, 0, 0, "t7_arm");
    idle(10);
    op_chk(C_STATUS, 0, 32'hC000_0010, "t7_armed");
    tick(0, 1, 3'd0, 32'd0, 1, 0, 32'd0, "t7_trigger");
    idle(1);
    op_chk(C_STATUS, 0, 32'h4000_0110, "t7_running");
    op_chk(C_STOP, 0, 0, "t7_stop");
    op_chk(C_POP, 0, 32'd1, "t7_pop");
`else
    // op 5 without the trigger feature is a NOP
    op_chk(C_ARM, 0, 0, "t7_arm_nop");
    op_chk(C_STATUS, 0, 32'h8000_0010, "t7_status_nop");
`endif

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      int k;
      logic [31:0] b;
      logic [2:0] op;
      bit tr;
      k  = $urandom_range(0, 99);
      b  = $urandom;
      b[31:8] = 24'($urandom_range(0, 5));
      op = 3'($urandom_range(0, 7));
      tr = ($urandom_range(0, 7) == 0);
      if (k < 50)
        tick(0, 1, op, b, tr, 0, 32'd0, "rnd_idle");
      else if (k < 55)
        tick(1, 0, op, b, tr, 0, 32'd0, "rnd_wrong_id");
      else if (k < 75)
        tick(1, 1, C_POP, b, tr, 0, 32'd0, "rnd_pop");
      else
        tick(1, 1, op, b, tr, 0, 32'd0, "rnd_op");
    end

    idle(2);
    total++;
    if (expq.size() != 0) begin
      bad++;
      $display("FAIL missing_done got=%0d pending want=0", expq.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
